gate_seq_ctrl: RTL and testbench

- Sequencer and self-checker for the 2-input gate datapath on the iCE40 stick.
- Drives the gate inputs (in1, in2) through all four input vectors and samples the 5-bit gate result bus (AND, OR, XOR, NAND, NOR in bits 0..4).
- Mirrors the result onto the LEDs and flags any mismatch against the expected truth table.
- Steps automatically on a slow tick or manually on a debounced button press.

---
 rtl/gate_seq_pkg.sv | 27 ++
 rtl/gate_seq_ctrl_btn_debounce.sv | 58 +++++
 rtl/gate_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_gate_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared constants for the gate sequencer: widths, FSM encodings and the
// expected truth table of the 5-output gate datapath.
package gate_seq_pkg;

  localparam int GATE_W = 5;
  localparam int VEC_W  = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_APPLY  = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_CHECK  = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  // Bits 4..0 = NOR, NAND, XOR, OR, AND; entry index is vec = {in1, in2}.
  localparam logic [3:0][GATE_W-1:0] EXP_TABLE = {
    5'b00011,
    5'b01110,
    5'b01110,
    5'b11000
  };

  function automatic logic [GATE_W-1:0] exp_res(input logic [VEC_W-1:0] vec);
    return EXP_TABLE[vec];
  endfunction

endpackage

// File: rtl/gate_seq_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so short glitches never flip it.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/gate_seq_ctrl.sv
// Gate datapath sequencer: walks the four input vectors, samples the result
// bus, mirrors it on the LEDs and latches any truth-table mismatch.
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int TICK_DIV  = 6_000_000,
  parameter int DB_CYCLES = 120_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_step,
  input  logic [GATE_W-1:0] gate_res,
  output logic              in1,
  output logic              in2,
  output logic [GATE_W-1:0] led,
  output logic              fail,
  output logic              auto_mode
);

  localparam int TICK_W = $clog2(TICK_DIV);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_i;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n_i = rst_sync_q[1];

  logic mode_level, mode_press;
  logic step_level, step_press;
  logic unused_levels;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode_db (
    .clk     (clk),
    .rst_n   (rst_n_i),
    .btn_raw (btn_mode),
    .level   (mode_level),
    .press   (mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk     (clk),
    .rst_n   (rst_n_i),
    .btn_raw (btn_step),
    .level   (step_level),
    .press   (step_press)
  );

  assign unused_levels = &{1'b0, mode_level, step_level};

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = (mode_press || tick) ? '0 : tick_cnt_q + 1'b1;
  end

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               in1_q, in1_d;
  logic               in2_q, in2_d;
  logic [GATE_W-1:0]  led_q, led_d;
  logic               fail_q, fail_d;
  logic               auto_q, auto_d;
  logic               advance;

  // The step/tick choice uses the mode before any toggle in this cycle.
  assign advance = auto_q ? tick : step_press;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    led_d   = led_q;
    fail_d  = fail_q;
    auto_d  = auto_q ^ mode_press;
    case (state_q)
      ST_APPLY: begin
        in1_d   = vec_q[1];
        in2_d   = vec_q[0];
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        led_d   = gate_res;
        fail_d  = fail_q | (gate_res != exp_res(vec_q));
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (advance) begin
          vec_d   = vec_q + 1'b1;
          state_d = ST_APPLY;
        end
      end
      default: begin
        state_d = ST_APPLY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt_q <= '0;
      state_q    <= ST_APPLY;
      vec_q      <= '0;
      in1_q      <= 1'b0;
      in2_q      <= 1'b0;
      led_q      <= '0;
      fail_q     <= 1'b0;
      auto_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      vec_q      <= vec_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      led_q      <= led_d;
      fail_q     <= fail_d;
      auto_q     <= auto_d;
    end
  end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign led       = led_q;
  assign fail      = fail_q;
  assign auto_mode = auto_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl with a reference gate model on gate_res
// and an expected-LED queue checked at every CHECK of the sequencer.
module tb_gate_seq_ctrl;
  import gate_seq_pkg::*;

  localparam int TICK_DIV  = 8;
  localparam int DB_CYCLES = 4;

  logic        clk;
  logic        rst_n;
  logic        btn_mode;
  logic        btn_step;
  logic [4:0]  gate_res;
  logic        in1;
  logic        in2;
  logic [4:0]  led;
  logic        fail;
  logic        auto_mode;

  logic        fault_en;
  logic [1:0]  exp_vec;
  logic        exp_fail;
  logic [4:0]  exp_q[$];
  int          n_asserts;
  int          n_fail;
  int unsigned cyc;
  int unsigned last_check_cyc;
  int unsigned last_gap;
  int unsigned n_step_pulse;

  gate_seq_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_step  (btn_step),
    .gate_res  (gate_res),
    .in1       (in1),
    .in2       (in2),
    .led       (led),
    .fail      (fail),
    .auto_mode (auto_mode)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.step_press) n_step_pulse <= n_step_pulse + 1;
  end

  function automatic logic [4:0] gate_model(input logic a, input logic b);
    return {~(a | b), ~(a & b), a ^ b, a | b, a & b};
  endfunction

  // Reference gate datapath, with an optional stuck-low XOR for vector 1.
  always_comb begin
    gate_res = gate_model(in1, in2);
    if (fault_en && !in1 && in2) gate_res[2] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] v, input logic faulty);
    logic [4:0] e;
    e = gate_model(v[1], v[0]);
    if (faulty) e[2] = 1'b0;
    exp_q.push_back(e);
  endtask

  // Wait for the next CHECK, then compare the registered results.
  task automatic next_check(input string tag, input logic [1:0] v);
    int i;
    logic [4:0] e;
    i = 0;
    while (i < 60 && dut.state_q != ST_CHECK) begin
      @(negedge clk);
      i++;
    end
    e = exp_q.pop_front();
    if (dut.state_q != ST_CHECK) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    chk({tag, "_led"}, 32'(led), 32'(e));
    chk({tag, "_vec"}, 32'({in1, in2}), 32'(v));
    chk({tag, "_fail"}, 32'(fail), 32'(exp_fail));
    last_gap       = cyc - last_check_cyc;
    last_check_cyc = cyc;
  endtask

  task automatic step_and_check(input string tag);
    exp_vec = exp_vec + 2'd1;
    push_exp(exp_vec, 1'b0);
    btn_step = 1'b1;
    next_check(tag, exp_vec);
    repeat (12) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int unsigned pulses0;
    int i;
    n_asserts      = 0;
    n_fail         = 0;
    cyc            = 0;
    last_check_cyc = 0;
    last_gap       = 0;
    n_step_pulse   = 0;
    fault_en       = 1'b0;
    exp_fail       = 1'b0;
    exp_vec        = 2'd0;
    btn_mode       = 1'b0;
    btn_step       = 1'b0;
    rst_n          = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in1", 32'(in1), 32'd0);
    chk("rst_in2", 32'(in2), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_auto", 32'(auto_mode), 32'd1);
    rst_n = 1'b1;

    // AUTO: one full lap and back to vector 0, one advance per tick.
    for (int k = 0; k < 5; k++) begin
      exp_vec = 2'(k);
      push_exp(exp_vec, 1'b0);
      next_check("auto", exp_vec);
      if (k > 0) chk("auto_gap", last_gap, TICK_DIV);
    end

    // Broken XOR on vector 1 latches fail for the rest of the run.
    fault_en = 1'b1;
    exp_vec  = 2'd1;
    exp_fail = 1'b1;
    push_exp(exp_vec, 1'b1);
    next_check("fault", exp_vec);
    fault_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_vec = exp_vec + 2'd1;
      push_exp(exp_vec, 1'b0);
      next_check("sticky", exp_vec);
    end

    // The next tick lands before the mode press is accepted.
    exp_vec = exp_vec + 2'd1;
    push_exp(exp_vec, 1'b0);
    btn_mode = 1'b1;
    next_check("mode_last_auto", exp_vec);
    repeat (12) @(negedge clk);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    chk("manual_mode", 32'(auto_mode), 32'd0);

    for (int k = 0; k < 3; k++) step_and_check("manual_step");
    chk("manual_three", 32'(exp_vec), 32'd3);

    pulses0 = n_step_pulse;
    repeat (4 * TICK_DIV) @(negedge clk);
    chk("no_tick_vec", 32'({in1, in2}), 32'(exp_vec));
    chk("no_tick_pulse", n_step_pulse - pulses0, 32'd0);

    // Glitches shorter than the debounce window.
    for (int k = 0; k < 6; k++) begin
      btn_step = 1'b1;
      @(negedge clk);
      btn_step = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("bounce_pulse", n_step_pulse - pulses0, 32'd0);
    chk("bounce_vec", 32'({in1, in2}), 32'(exp_vec));

    pulses0 = n_step_pulse;
    step_and_check("clean_step");
    chk("clean_pulse", n_step_pulse - pulses0, 32'd1);

    // A step pulse injected while settling must be dropped.
    exp_vec = exp_vec + 2'd1;
    push_exp(exp_vec, 1'b0);
    btn_step = 1'b1;
    i = 0;
    while (i < 60 && dut.state_q != ST_SETTLE) begin
      @(negedge clk);
      i++;
    end
    chk("settle_reached", 32'(dut.state_q), 32'(ST_SETTLE));
    force dut.step_press = 1'b1;
    @(negedge clk);
    release dut.step_press;
    next_check("settle_step", exp_vec);
    repeat (12) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    chk("settle_dropped", 32'({in1, in2}), 32'(exp_vec));
    step_and_check("after_settle");

    while (exp_vec != 2'd1) step_and_check("walk");

    // Reset while the sequencer is checking vector 2.
    exp_vec  = 2'd2;
    btn_step = 1'b1;
    i = 0;
    while (i < 60 && dut.state_q != ST_CHECK) begin
      @(negedge clk);
      i++;
    end
    chk("check_reached", 32'(dut.state_q), 32'(ST_CHECK));
    chk("check_vec2", 32'({in1, in2}), 32'd2);
    rst_n    = 1'b0;
    btn_step = 1'b0;
    #1;
    chk("async_in1", 32'(in1), 32'd0);
    chk("async_in2", 32'(in2), 32'd0);
    chk("async_led", 32'(led), 32'd0);
    chk("async_fail", 32'(fail), 32'd0);
    chk("async_auto", 32'(auto_mode), 32'd1);
    repeat (5) @(negedge clk);
    chk("held_in", 32'({in1, in2}), 32'd0);
    rst_n    = 1'b1;
    exp_fail = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_vec = 2'(k);
      push_exp(exp_vec, 1'b0);
      next_check("restart", exp_vec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
